seg8_p2s_ctrl: RTL and testbench

- Sequencer between the 8-digit hex-to-segment decode and the serially-chained 74HC595-style display shift registers.
- Captures the 64-bit segment pattern (digit 7 in bits [7:0] … digit 0 in [63:56]) on request.
- Shifts the pattern out MSB-first on a divided serial clock, then pulses the register latch.
- Also generates the periodic flash (blink) enable consumed by the segment decode.

---
 rtl/seg8_p2s_ctrl_pkg.sv | 18 +
 rtl/seg8_blink_gen.sv | 30 +++
 rtl/seg8_p2s_ctrl.sv | 170 +++++++++++++++++
 tb/tb_seg8_p2s_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg8_p2s_ctrl_pkg.sv
// Shared definitions for the 8-digit segment serialiser: state encodings,
// frame length and default timing parameters.
package seg8_p2s_ctrl_pkg;

    localparam int FRAME_BITS     = 64;
    localparam int DEF_DIV        = 2;
    localparam int DEF_BLINK_LOG2 = 24;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_LATCH    = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

endpackage

// File: rtl/seg8_blink_gen.sv
// Free-running blink counter; flash is high for the first half of each
// 2^BLINK_LOG2 cycle period, starting high out of reset.
module seg8_blink_gen
    import seg8_p2s_ctrl_pkg::*;
#(
    parameter int BLINK_LOG2 = DEF_BLINK_LOG2
) (
    input  logic clk,
    input  logic rst,
    output logic flash
);

    logic [BLINK_LOG2-1:0] blink_cnt_q;
    logic [BLINK_LOG2-1:0] blink_cnt_d;

    always_comb begin
        blink_cnt_d = blink_cnt_q + BLINK_LOG2'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
        end
    end

    assign flash = ~blink_cnt_q[BLINK_LOG2-1];

endmodule

// File: rtl/seg8_p2s_ctrl.sv
// Captures a 64-bit segment pattern and shifts it MSB-first into a 74HC595
// chain, then latches it. Optional macro SEG8_AUTO_REFRESH_EN adds a periodic refresh.
module seg8_p2s_ctrl
    import seg8_p2s_ctrl_pkg::*;
#(
    parameter int DIV        = DEF_DIV,
    parameter int BLINK_LOG2 = DEF_BLINK_LOG2
`ifdef SEG8_AUTO_REFRESH_EN
    ,
    parameter int REFRESH_CYCLES = 1000000
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] seg_txt,
    output logic                  busy,
    output logic                  done,
    output logic                  s_clk,
    output logic                  s_data,
    output logic                  s_clr_n,
    output logic                  s_ld,
    output logic                  flash
);

    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   shadow_q, shadow_d;
    logic [5:0]              bit_cnt_q, bit_cnt_d;
    logic [7:0]              div_cnt_q, div_cnt_d;
    logic                    pending_q, pending_d;
    logic                    s_clk_q, s_clk_d;
    logic                    s_ld_q, s_ld_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic                    clr_n_q;
    logic                    req;
    logic                    div_last;

`ifdef SEG8_AUTO_REFRESH_EN
    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic [REF_W-1:0] ref_cnt_q, ref_cnt_d;
    logic             ref_wrap;

    always_comb begin
        ref_wrap  = (ref_cnt_q == REF_W'(REFRESH_CYCLES - 1));
        ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + REF_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_cnt_q <= '0;
        end else begin
            ref_cnt_q <= ref_cnt_d;
        end
    end

    assign req = start | ref_wrap;
`else
    assign req = start;
`endif

    assign div_last = (div_cnt_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        // A request arriving while a frame is in flight is remembered, not acted on.
        pending_d = pending_q | (req && (state_q != ST_IDLE));

        unique case (state_q)
            ST_IDLE: begin
                if (req || pending_q) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                shadow_d  = seg_txt;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                pending_d = req;
                state_d   = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    state_d   = ST_SHIFT_HI;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            ST_SHIFT_HI: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    shadow_d  = {shadow_q[FRAME_BITS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 6'd1;
                    state_d   = (bit_cnt_q == 6'd63) ? ST_LATCH : ST_SHIFT_LO;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            ST_LATCH: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    state_d   = ST_DONE;
                end else begin
                    div_cnt_d = div_cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs decoded from the next state so they are flops aligned with it.
        s_clk_d = (state_d == ST_SHIFT_HI);
        s_ld_d  = (state_d == ST_LATCH);
        done_d  = (state_d == ST_DONE);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shadow_q  <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            pending_q <= 1'b0;
            s_clk_q   <= 1'b0;
            s_ld_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            clr_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            pending_q <= pending_d;
            s_clk_q   <= s_clk_d;
            s_ld_q    <= s_ld_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            clr_n_q   <= 1'b1;
        end
    end

    seg8_blink_gen #(
        .BLINK_LOG2(BLINK_LOG2)
    ) u_blink (
        .clk  (clk),
        .rst  (rst),
        .flash(flash)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign s_clk   = s_clk_q;
    assign s_data  = shadow_q[FRAME_BITS-1];
    assign s_clr_n = clr_n_q;
    assign s_ld    = s_ld_q;

endmodule

// File: tb/tb_seg8_p2s_ctrl.sv
// Scoreboard bench for seg8_p2s_ctrl: stimulus queues expected frames,
// a monitor reassembles serial frames and compares on each done pulse.
module tb_seg8_p2s_ctrl;

    localparam int DIV      = 2;
    localparam int BL       = 4;
    localparam int FRAME_LAT = 1 + 129 * DIV;
    localparam int FRAME_GAP = FRAME_LAT + 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] seg_txt = 64'h0;
    logic        busy, done, s_clk, s_data, s_clr_n, s_ld, flash;

    seg8_p2s_ctrl #(
        .DIV(DIV),
        .BLINK_LOG2(BL)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .seg_txt(seg_txt),
        .busy   (busy),
        .done   (done),
        .s_clk  (s_clk),
        .s_data (s_data),
        .s_clr_n(s_clr_n),
        .s_ld   (s_ld),
        .flash  (flash)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] val;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    int   cyc = 0;
    int   blink_k = 0;
    int   n_pass = 0;
    int   n_chk = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    // cycle counter and blink reference: flash high for 2^(BL-1) cycles, low for 2^(BL-1)
    initial forever begin
        @(posedge clk);
        cyc++;
        if (rst) blink_k = 0;
        else blink_k++;
    end

    initial forever begin
        @(negedge clk);
        if (!rst) check("flash", {63'b0, flash}, {63'b0, ((blink_k % (1 << BL)) < (1 << (BL - 1)))});
    end

    // monitor: rebuild the shifted frame from s_data at each rising s_clk
    initial begin
        logic        prev_sclk;
        logic [63:0] cap;
        int          nbits, ld_cnt;
        exp_t        e;
        prev_sclk = 1'b0; cap = '0; nbits = 0; ld_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_sclk = 1'b0; cap = '0; nbits = 0; ld_cnt = 0;
            end else begin
                if (s_clk && !prev_sclk) begin
                    cap = {cap[62:0], s_data};
                    nbits++;
                end
                prev_sclk = s_clk;
                if (s_ld) ld_cnt++;
                if (done) begin
                    done_cnt++;
                    if (sb_q.size() == 0) begin
                        check("unexpected_done", 64'd1, 64'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check("frame_value", cap, e.val);
                        check("frame_bits", 64'(nbits), 64'd64);
                        check("done_cycle", 64'(cyc), 64'(e.cyc));
                        check("s_ld_width", 64'(ld_cnt), 64'(DIV));
                    end
                    cap = '0; nbits = 0; ld_cnt = 0;
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // one-cycle start pulse; returns the edge index at which it is sampled
    task automatic pulse_start(output int n);
        @(posedge clk);
        #1;
        start = 1'b1;
        n = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic push_exp(input logic [63:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        sb_q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int b;
        b = budget;
        while (sb_q.size() != 0 && b > 0) begin
            @(negedge clk);
            b--;
        end
        if (sb_q.size() != 0) begin
            check("drain_timeout", 64'(sb_q.size()), 64'd0);
            sb_q.delete();
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          d0;
        logic [63:0] v;

        // reset state
        @(negedge clk);
        check("rst_s_clk", {63'b0, s_clk}, 64'd0);
        check("rst_s_data", {63'b0, s_data}, 64'd0);
        check("rst_s_ld", {63'b0, s_ld}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_s_clr_n", {63'b0, s_clr_n}, 64'd0);
        check("rst_flash", {63'b0, flash}, 64'd1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("clr_n_before_edge", {63'b0, s_clr_n}, 64'd0);
        @(negedge clk);
        check("clr_n_after_edge", {63'b0, s_clr_n}, 64'd1);
        check("idle_busy", {63'b0, busy}, 64'd0);
        check("idle_s_clk", {63'b0, s_clk}, 64'd0);

        // single frame, corner bits
        seg_txt = 64'h8000_0000_0000_0001;
        pulse_start(n);
        push_exp(64'h8000_0000_0000_0001, n + FRAME_LAT);
        @(negedge clk);
        check("busy_in_frame", {63'b0, busy}, 64'd1);
        wait_drain(600);

        // start held: back-to-back frames plus one pending frame
        seg_txt = 64'hFFFF_0000_A5A5_3C3C;
        @(posedge clk);
        #1 start = 1'b1;
        n = cyc + 1;
        for (int k = 0; k < 4; k++) push_exp(64'hFFFF_0000_A5A5_3C3C, n + FRAME_LAT + k * FRAME_GAP);
        repeat (600) @(posedge clk);
        #1 start = 1'b0;
        wait_drain(1500);

        // request during frame plus seg_txt change: second frame takes new value
        seg_txt = 64'hDEAD_BEEF_0BAD_F00D;
        d0 = done_cnt;
        pulse_start(n);
        push_exp(64'hDEAD_BEEF_0BAD_F00D, n + FRAME_LAT);
        push_exp(64'h0123_4567_89AB_CDEF, n + FRAME_GAP + FRAME_LAT);
        wait_until(n + 99);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_until(n + 150);
        seg_txt = 64'h0123_4567_89AB_CDEF;
        wait_drain(1000);
        repeat (300) @(negedge clk);
        check("pending_done_count", 64'(done_cnt - d0), 64'd2);

        // reset in the middle of shifting
        seg_txt = 64'hCAFE_F00D_1234_5678;
        pulse_start(n);
        push_exp(64'hCAFE_F00D_1234_5678, n + FRAME_LAT);
        wait_until(n + 120);
        #1 rst = 1'b1;
        #1;
        check("midrst_s_clk", {63'b0, s_clk}, 64'd0);
        check("midrst_s_ld", {63'b0, s_ld}, 64'd0);
        check("midrst_busy", {63'b0, busy}, 64'd0);
        check("midrst_s_clr_n", {63'b0, s_clr_n}, 64'd0);
        check("midrst_s_data", {63'b0, s_data}, 64'd0);
        sb_q.delete();
        d0 = done_cnt;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (400) @(negedge clk);
        check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
        check("midrst_idle", {63'b0, busy}, 64'd0);

        // randomized patterns
        for (int k = 0; k < 4; k++) begin
            v = {$urandom, $urandom};
            seg_txt = v;
            pulse_start(n);
            push_exp(v, n + FRAME_LAT);
            wait_drain(600);
            repeat ($urandom_range(0, 7)) @(posedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
